// File: rtl/aes_state_array_if.sv
// aes_state_array_if
//   Bundles the byte-serial AES state register's command and data signals.
//   slave  : the state register itself (commands and data in, taps and status out)
//   master : the datapath controller driving it
//   Signals:
//     din[7:0]      byte from the datapath mux
//     shift_en      shift one byte in at s[15]
//     col_shift     shift one column in from col_in
//     col_in[31:0]  MixColumns result, [31:24] -> s[12]
//     sr_start      start ShiftRows
//     sr_inv        direction, sampled with sr_start (1 = inverse)
//     dout[7:0]     s[0]
//     col_out[31:0] {s[0],s[1],s[2],s[3]}
//     byte_cnt[3:0] accepted byte shifts modulo 16
//     full          pulse after the 16th byte of a block
//     busy          ShiftRows in progress
//     sr_done       pulse when ShiftRows completes
interface aes_state_array_if;
  logic [7:0]  din;
  logic        shift_en;
  logic        col_shift;
  logic [31:0] col_in;
  logic        sr_start;
  logic        sr_inv;
  logic [7:0]  dout;
  logic [31:0] col_out;
  logic [3:0]  byte_cnt;
  logic        full;
  logic        busy;
  logic        sr_done;

  modport slave (
    input  din, shift_en, col_shift, col_in, sr_start, sr_inv,
    output dout, col_out, byte_cnt, full, busy, sr_done
  );

  modport master (
    output din, shift_en, col_shift, col_in, sr_start, sr_inv,
    input  dout, col_out, byte_cnt, full, busy, sr_done
  );
endinterface

// File: rtl/aes_state_array.sv
// aes_state_array
//   Byte-serial 16-byte AES state register, column-major (index = 4*col + row).
//   Bytes stream in at s[15] and out at s[0]; whole columns stream in from the
//   MixColumns unit; forward/inverse ShiftRows runs in place, one row per cycle.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - aes_state_array_if.slave (commands, data, taps and status)
module aes_state_array (
  input  logic               clk,
  input  logic               rst,
  aes_state_array_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROW1, ROW2, ROW3} state_e;

  state_e            fsm_q;
  logic [15:0][7:0]  s_q;
  logic              inv_q;
  logic [3:0]        cnt_q;
  logic              full_q;
  logic              busy_q;
  logic              done_q;

  // Rotate row r of the state: forward takes from column (c+r), inverse from
  // column (c-r); 2-bit arithmetic gives the mod-4 wrap for free.
  function automatic logic [15:0][7:0] rotate_row(
    input logic [15:0][7:0] s,
    input logic [1:0]       r,
    input logic             inv
  );
    logic [15:0][7:0] res;
    logic [1:0]       src;
    res = s;
    for (int c = 0; c < 4; c++) begin
      src = inv ? (2'(c) - r) : (2'(c) + r);
      res[{2'(c), r}] = s[{src, r}];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      s_q    <= '0;
      inv_q  <= 1'b0;
      cnt_q  <= 4'd0;
      full_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      full_q <= 1'b0;
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          // Priority: sr_start, then col_shift, then shift_en.
          if (bus.sr_start) begin
            inv_q  <= bus.sr_inv;
            busy_q <= 1'b1;
            fsm_q  <= ROW1;
          end else if (bus.col_shift) begin
            s_q <= {bus.col_in[7:0], bus.col_in[15:8],
                    bus.col_in[23:16], bus.col_in[31:24], s_q[15:4]};
          end else if (bus.shift_en) begin
            s_q    <= {bus.din, s_q[15:1]};
            cnt_q  <= cnt_q + 4'd1;
            full_q <= (cnt_q == 4'd15);
          end
        end
        ROW1: begin
          s_q   <= rotate_row(s_q, 2'd1, inv_q);
          fsm_q <= ROW2;
        end
        ROW2: begin
          s_q   <= rotate_row(s_q, 2'd2, inv_q);
          fsm_q <= ROW3;
        end
        ROW3: begin
          s_q    <= rotate_row(s_q, 2'd3, inv_q);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Output taps straight off the state register.
  assign bus.dout = s_q[0];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col_out
      assign bus.col_out[31-8*gi -: 8] = s_q[gi];
    end
  endgenerate

  assign bus.byte_cnt = cnt_q;
  assign bus.full     = full_q;
  assign bus.busy     = busy_q;
  assign bus.sr_done  = done_q;

endmodule
